// File: rtl/mem_responder.sv
// Memory responder for the CPU memory port: writes land at the sampling edge,
// reads return through a two-stage pipeline with a one-cycle rvalid pulse.
module mem_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [7:0]        rd_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [7:0]        r_rd_count;

    // Stage 2 reads the array before a same-edge write lands, so a write one
    // edge after the read's sampling edge is never visible to that read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rd_count <= 8'd0;
        end else begin
            if (wr) begin
                r_mem[addr] <= wdata;
            end
            r_s1_valid <= rd;
            if (rd) begin
                r_s1_addr <= addr;
            end
            r_rvalid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rdata    <= r_mem[r_s1_addr];
                r_rd_count <= r_rd_count + 8'd1;
            end
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed plan checks plus randomized traffic
// against a queue-based model that captures read data at the sampling edge.
module tb_mem_responder;

    logic       clk;
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic [7:0] rd_count;

    int n_chk  = 0;
    int n_pass = 0;

    mem_responder #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
    } pend_t;

    logic [7:0] mm [16];
    pend_t      q[$];
    int         cyc = 0;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic [7:0] exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: read data is captured from the model array at the sampling
    // edge (after that edge's write) and delivered one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mm[i] = 8'h00;
            q.delete();
            exp_valid = 1'b0;
            exp_rdata = 8'h00;
            exp_count = 8'h00;
        end else begin
            pend_t p;
            cyc++;
            exp_valid = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_rdata = q[0].data;
                exp_count = exp_count + 8'd1;
                void'(q.pop_front());
            end
            if (wr) mm[addr] = wdata;
            if (rd) begin
                p.due  = cyc + 1;
                p.data = mm[addr];
                q.push_back(p);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_rvalid", {31'd0, rvalid}, {31'd0, exp_valid});
            chk("model_rdata", {24'd0, rdata}, {24'd0, exp_rdata});
            chk("model_rd_count", {24'd0, rd_count}, {24'd0, exp_count});
        end
    end

    task automatic cycle(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 4'h0; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", {24'd0, rdata}, 32'h00);
        chk("reset_rvalid", {31'd0, rvalid}, 32'h0);
        chk("reset_rd_count", {24'd0, rd_count}, 32'h00);
        rst_n = 1'b1;

        // Read of a cleared word
        cycle(1'b1, 1'b0, 4'h1, 8'h00);
        idle();
        chk("first_read_rvalid", {31'd0, rvalid}, 32'h1);
        chk("first_read_rdata", {24'd0, rdata}, 32'h00);
        chk("first_read_count", {24'd0, rd_count}, 32'h01);
        idle();
        chk("rvalid_one_cycle", {31'd0, rvalid}, 32'h0);
        chk("rdata_hold", {24'd0, rdata}, 32'h00);

        // Write then read back
        cycle(1'b0, 1'b1, 4'h1, 8'h01);
        cycle(1'b1, 1'b0, 4'h1, 8'h00);
        idle();
        chk("wr_rd_1", {24'd0, rdata}, 32'h01);
        chk("wr_rd_1_valid", {31'd0, rvalid}, 32'h1);
        cycle(1'b0, 1'b1, 4'h2, 8'h02);
        cycle(1'b0, 1'b1, 4'h4, 8'h04);
        cycle(1'b1, 1'b0, 4'h2, 8'h00);
        cycle(1'b1, 1'b0, 4'h4, 8'h00);
        chk("wr_rd_2", {24'd0, rdata}, 32'h02);
        idle();
        chk("wr_rd_4", {24'd0, rdata}, 32'h04);

        // Write-first on same edge, then a later write is not visible
        cycle(1'b1, 1'b1, 4'h3, 8'hA5);
        cycle(1'b0, 1'b1, 4'h3, 8'h5A);
        chk("write_first", {24'd0, rdata}, 32'hA5);
        cycle(1'b1, 1'b0, 4'h3, 8'h00);
        idle();
        chk("later_write_seen", {24'd0, rdata}, 32'h5A);

        // Back-to-back reads
        cycle(1'b1, 1'b0, 4'h1, 8'h00);
        cycle(1'b1, 1'b0, 4'h2, 8'h00);
        chk("b2b_0_data", {24'd0, rdata}, 32'h01);
        chk("b2b_0_valid", {31'd0, rvalid}, 32'h1);
        cycle(1'b1, 1'b0, 4'h4, 8'h00);
        chk("b2b_1_data", {24'd0, rdata}, 32'h02);
        chk("b2b_1_valid", {31'd0, rvalid}, 32'h1);
        idle();
        chk("b2b_2_data", {24'd0, rdata}, 32'h04);
        chk("b2b_2_valid", {31'd0, rvalid}, 32'h1);
        chk("b2b_count", {24'd0, rd_count}, 32'd9);

        // Reset mid-read drops the in-flight read and clears the array
        cycle(1'b1, 1'b0, 4'h1, 8'h00);
        rd = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("midrst_rdata", {24'd0, rdata}, 32'h00);
        chk("midrst_count", {24'd0, rd_count}, 32'h00);
        rst_n = 1'b1;
        idle();
        chk("midrst_no_pulse", {31'd0, rvalid}, 32'h0);
        cycle(1'b1, 1'b0, 4'h4, 8'h00);
        idle();
        chk("midrst_mem_clear", {24'd0, rdata}, 32'h00);
        chk("midrst_read_valid", {31'd0, rvalid}, 32'h1);

        // Randomized traffic, with an occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
        end
        idle();
        idle();

        // Counter wrap
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
        end
        chk("count_255", {24'd0, rd_count}, 32'd255);
        idle();
        chk("count_wrap", {24'd0, rd_count}, 32'd0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
